// File: rtl/axi4_sram_pkg.sv
// Shared types and helpers for the AXI4 burst SRAM slave.
//   burst_t        AXI burst encodings (FIXED/INCR/WRAP)
//   RESP_*         AXI response codes
//   w_state_t      write-engine states (also exported on w_state_dbg)
//   r_state_t      read-engine states  (also exported on r_state_dbg)
//   wrap_ok()      legal WRAP lengths (2, 4, 8 or 16 beats)
//   next_addr()    per-beat address step for all burst types
package axi4_sram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_LAT  = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LAT  = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Addresses are carried at 64 bits so any ADDR_W up to 64 fits; callers
    // zero-extend in and slice out. A WRAP with an illegal length steps as INCR.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [63:0] incr;
        logic [63:0] mask;
        incr = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (burst == BURST_WRAP && wrap_ok(len))
            next_addr = (addr & ~mask) | ((addr + incr) & mask);
        else
            // INCR: later beats are aligned to the transfer size.
            next_addr = (addr & ~(incr - 64'd1)) + incr;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-channel burst address generator.
//   load/addr_in/size_in/len_in/burst_in : captured on the address handshake
//   advance    : step to the next beat (beat handshake)
//   peek_next  : 1 = present the beat after the current one, 0 = current beat
//   word_idx   : SRAM word index of the presented beat
//   dec_err    : presented beat address lies above the SRAM
//   last       : presented beat is beat len
//   slv_err    : burst-level error (reserved burst, bad WRAP length, oversize)
module axi4_burst_addr_gen
    import axi4_sram_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [2:0]            size_in,
    input  logic [7:0]            len_in,
    input  logic [1:0]            burst_in,
    input  logic                  advance,
    input  logic                  peek_next,
    output logic [DEPTH_LOG2-1:0] word_idx,
    output logic                  dec_err,
    output logic                  last,
    output logic                  slv_err
);

    localparam int OFF    = $clog2(DATA_W / 8);
    localparam int IDX_HI = DEPTH_LOG2 + OFF;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic [63:0]       nxt64;

    always_comb nxt64 = next_addr(64'(addr_q), size_q, len_q, burst_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            slv_err <= 1'b0;
        end else if (load) begin
            addr_q  <= addr_in;
            size_q  <= size_in;
            len_q   <= len_in;
            burst_q <= burst_in;
            beat_q  <= '0;
            slv_err <= (burst_in == 2'b11) ||
                       (burst_in == BURST_WRAP && !wrap_ok(len_in)) ||
                       (int'(size_in) > OFF);
        end else if (advance) begin
            addr_q <= nxt64[ADDR_W-1:0];
            beat_q <= beat_q + 8'd1;
        end
    end

    // A carry out of the top of the next address also counts as out of range.
    always_comb begin
        if (peek_next) begin
            word_idx = nxt64[IDX_HI-1:OFF];
            dec_err  = (nxt64 >> IDX_HI) != 64'd0;
            last     = (beat_q + 8'd1) == len_q;
        end else begin
            word_idx = addr_q[IDX_HI-1:OFF];
            dec_err  = (addr_q >> IDX_HI) != '0;
            last     = beat_q == len_q;
        end
    end

endmodule

// File: rtl/axi4_burst_sram.sv
// AXI4 slave over an on-chip word-addressed SRAM with independent read and
// write engines, FIXED/INCR/WRAP bursts, byte strobes, ID echo and
// programmable access latency.
// Ports: clk, reset (sync, active-high); AXI4 AW/W/B/AR/R channels;
//   w_state_dbg / r_state_dbg expose the write/read engine states.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid && ready are both 1; the sender holds its payload stable while valid
// is high and ready is low, and never withdraws valid before the transfer.
module axi4_burst_sram
    import axi4_sram_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_W-1:0]     bid,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [ID_W-1:0]     rid,
    output logic [1:0]          w_state_dbg,
    output logic [1:0]          r_state_dbg
);

    localparam int         STRB_W  = DATA_W / 8;
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [7:0] RD_INIT = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_INIT = 8'(WR_LAT - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;

    logic aw_fire, w_fire, ar_fire, r_fire;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    logic [DEPTH_LOG2-1:0] w_idx, r_idx;
    logic                  w_dec, r_dec, w_last, r_last, w_slv, r_slv;

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_wr_gen (
        .clk(clk), .reset(reset), .load(aw_fire), .addr_in(awaddr), .size_in(awsize),
        .len_in(awlen), .burst_in(awburst), .advance(w_fire), .peek_next(1'b0),
        .word_idx(w_idx), .dec_err(w_dec), .last(w_last), .slv_err(w_slv)
    );

    // In R_DATA the register is reloaded on a beat handshake, so it must
    // fetch the beat after the one currently on the bus.
    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rd_gen (
        .clk(clk), .reset(reset), .load(ar_fire), .addr_in(araddr), .size_in(arsize),
        .len_in(arlen), .burst_in(arburst), .advance(r_fire), .peek_next(r_state == R_DATA),
        .word_idx(r_idx), .dec_err(r_dec), .last(r_last), .slv_err(r_slv)
    );

    // ---------------- write engine ----------------
    logic [7:0] w_cnt;
    logic       w_slv_sticky, w_dec_sticky, w_beat_err;
    logic [1:0] w_resp_now;

    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_n;
    end

    always_comb begin
        w_state_n = w_state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_state_n = W_LAT;
            end
            W_LAT:  if (w_cnt == 8'd0) w_state_n = W_RESP;
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // wlast must coincide exactly with beat awlen.
    assign w_beat_err = wlast ^ w_last;

    always_comb begin
        if (w_dec_sticky || w_dec)
            w_resp_now = RESP_DECERR;
        else if (w_slv_sticky || w_beat_err || w_slv)
            w_resp_now = RESP_SLVERR;
        else
            w_resp_now = RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_cnt        <= '0;
            bid          <= '0;
            bresp        <= RESP_OKAY;
            w_slv_sticky <= 1'b0;
            w_dec_sticky <= 1'b0;
        end else begin
            if (aw_fire) begin
                bid          <= awid;
                w_slv_sticky <= 1'b0;
                w_dec_sticky <= 1'b0;
            end
            if (w_fire) begin
                w_slv_sticky <= w_slv_sticky | w_beat_err;
                w_dec_sticky <= w_dec_sticky | w_dec;
                if (wlast) begin
                    w_cnt <= WR_INIT;
                    bresp <= w_resp_now;
                end
            end
            if (w_state == W_LAT && w_cnt != 8'd0)
                w_cnt <= w_cnt - 8'd1;
        end
    end

    // Byte-strobed write port; out-of-range beats are dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_fire && !w_dec) begin
            for (int i = 0; i < STRB_W; i++)
                if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // ---------------- read engine ----------------
    logic [7:0] r_cnt;
    logic       r_load;

    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_n;
    end

    always_comb begin
        r_state_n = r_state;
        arready   = 1'b0;
        rvalid    = 1'b0;
        r_load    = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_n = R_LAT;
            end
            R_LAT: if (r_cnt == 8'd0) begin
                r_state_n = R_DATA;
                r_load    = 1'b1;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (rlast) r_state_n = R_IDLE;
                    else       r_load    = 1'b1;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Synchronous read port: a same-edge write leaves the old word in rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            rid   <= '0;
            rdata <= '0;
            rresp <= RESP_OKAY;
            rlast <= 1'b0;
        end else begin
            if (ar_fire) begin
                rid   <= arid;
                r_cnt <= RD_INIT;
            end
            if (r_state == R_LAT && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
            if (r_load) begin
                rdata <= r_dec ? '0 : mem[r_idx];
                rresp <= r_dec ? RESP_DECERR : (r_slv ? RESP_SLVERR : RESP_OKAY);
                rlast <= r_last;
            end
        end
    end

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi4_burst_sram.sv
module tb_axi4_burst_sram;
  import axi4_sram_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              awvalid = 0, awready;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [ID_W-1:0]   awid = '0;
  logic [7:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              wvalid = 0, wready;
  logic [DATA_W-1:0] wdata = '0;
  logic [7:0]        wstrb = '0;
  logic              wlast = 0;
  logic              bvalid, bready = 0;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              arvalid = 0, arready;
  logic [ADDR_W-1:0] araddr = '0;
  logic [ID_W-1:0]   arid = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              rvalid, rready = 0;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  logic [1:0]        w_state_dbg, r_state_dbg;

  axi4_burst_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH_LOG2(12),
                    .RD_LAT(2), .WR_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1;
    while (!awready && n < 20) begin tick(); n++; end
    check("aw_accept", 64'(awready), 64'd1);
    tick();
    awvalid = 0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1;
    while (!arready && n < 20) begin tick(); n++; end
    check("ar_accept", 64'(arready), 64'd1);
    tick();
    arvalid = 0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1;
    while (!wready && n < 20) begin tick(); n++; end
    check("w_accept", 64'(wready), 64'd1);
    tick();
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_get(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
    int n = 0;
    bready = 1;
    while (!bvalid && n < 20) begin tick(); n++; end
    check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    check({tag, "_bid"}, 64'(bid), 64'(exp_id));
    tick();
    bready = 0;
  endtask

  // Collects nbeats read beats against exp_q; while stalled the bus must
  // keep showing the head of the queue.
  task automatic r_get(input string tag, input int nbeats, input bit toggle,
                       input logic [1:0] exp_resp, input logic [3:0] exp_id);
    int got = 0;
    int cyc = 0;
    while (got < nbeats && cyc < 100) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid) begin
        check({tag, "_rdata"}, rdata, exp_q[0]);
        check({tag, "_rlast"}, 64'(rlast), 64'(got == nbeats - 1));
        check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        check({tag, "_rid"}, 64'(rid), 64'(exp_id));
        if (rready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      tick();
      cyc++;
    end
    rready = 0;
    check({tag, "_beats"}, 64'(got), 64'(nbeats));
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) tick();
    reset = 0;
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_resp", {60'd0, rresp, bresp}, 64'd0);
    check("rst_ids", {56'd0, rid, bid}, 64'd0);

    // 1: single beat, exact write/read latency
    aw_send(32'h100, 8'd0, 3'd3, BURST_INCR, 4'd5);
    w_beat(64'h1122334455667788, 8'hFF, 1'b1);
    check("t1_bvalid_c0", 64'(bvalid), 64'd0);
    tick();
    check("t1_bvalid_c1", 64'(bvalid), 64'd0);
    tick();
    check("t1_bvalid_c2", 64'(bvalid), 64'd1);
    b_get("t1", RESP_OKAY, 4'd5);
    ar_send(32'h100, 8'd0, 3'd3, BURST_INCR, 4'd3);
    check("t1_rvalid_c0", 64'(rvalid), 64'd0);
    tick();
    check("t1_rvalid_c1", 64'(rvalid), 64'd0);
    tick();
    check("t1_rvalid_c2", 64'(rvalid), 64'd1);
    exp_q.push_back(64'h1122334455667788);
    r_get("t1", 1, 1'b0, RESP_OKAY, 4'd3);

    // 2: INCR len3 write, read back with rready toggling
    aw_send(32'h200, 8'd3, 3'd3, BURST_INCR, 4'd1);
    for (int i = 1; i <= 4; i++) w_beat(64'(i), 8'hFF, i == 4);
    b_get("t2", RESP_OKAY, 4'd1);
    ar_send(32'h200, 8'd3, 3'd3, BURST_INCR, 4'd2);
    for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
    r_get("t2", 4, 1'b1, RESP_OKAY, 4'd2);

    // 3: WRAP len3 starting at 0x118 wraps inside 0x100..0x11F
    aw_send(32'h100, 8'd3, 3'd3, BURST_INCR, 4'd6);
    w_beat(64'hA, 8'hFF, 1'b0);
    w_beat(64'hB, 8'hFF, 1'b0);
    w_beat(64'hC, 8'hFF, 1'b0);
    w_beat(64'hD, 8'hFF, 1'b1);
    b_get("t3", RESP_OKAY, 4'd6);
    ar_send(32'h118, 8'd3, 3'd3, BURST_WRAP, 4'd7);
    exp_q.push_back(64'hD); exp_q.push_back(64'hA);
    exp_q.push_back(64'hB); exp_q.push_back(64'hC);
    r_get("t3", 4, 1'b0, RESP_OKAY, 4'd7);

    // 4: partial strobe overwrites only the low four bytes
    aw_send(32'h300, 8'd0, 3'd3, BURST_INCR, 4'd0);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_get("t4a", RESP_OKAY, 4'd0);
    aw_send(32'h300, 8'd0, 3'd3, BURST_INCR, 4'd0);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_get("t4b", RESP_OKAY, 4'd0);
    ar_send(32'h300, 8'd0, 3'd3, BURST_INCR, 4'd0);
    exp_q.push_back(64'hFFFF_FFFF_0000_0000);
    r_get("t4", 1, 1'b0, RESP_OKAY, 4'd0);

    // 5: early wlast -> SLVERR via W_LAT; engine then takes a new AW
    aw_send(32'h400, 8'd3, 3'd3, BURST_INCR, 4'd7);
    w_beat(64'hA0, 8'hFF, 1'b0);
    w_beat(64'hA1, 8'hFF, 1'b0);
    w_beat(64'hA2, 8'hFF, 1'b1);
    check("t5_state_lat", 64'(w_state_dbg), 64'(W_LAT));
    b_get("t5", RESP_SLVERR, 4'd7);
    aw_send(32'h408, 8'd0, 3'd3, BURST_INCR, 4'd1);
    w_beat(64'hB0, 8'hFF, 1'b1);
    b_get("t5b", RESP_OKAY, 4'd1);
    ar_send(32'h400, 8'd1, 3'd3, BURST_INCR, 4'd8);
    exp_q.push_back(64'hA0); exp_q.push_back(64'hB0);
    r_get("t5", 2, 1'b0, RESP_OKAY, 4'd8);

    // address above the SRAM: DECERR, read data zero
    aw_send(32'h8000, 8'd0, 3'd3, BURST_INCR, 4'd2);
    w_beat(64'h55, 8'hFF, 1'b1);
    b_get("dec", RESP_DECERR, 4'd2);
    ar_send(32'h8000, 8'd0, 3'd3, BURST_INCR, 4'd2);
    exp_q.push_back(64'h0);
    r_get("dec", 1, 1'b0, RESP_DECERR, 4'd2);

    // reserved burst type behaves as INCR with SLVERR
    ar_send(32'h200, 8'd0, 3'd3, 2'b11, 4'd4);
    exp_q.push_back(64'd1);
    r_get("rsv", 1, 1'b0, RESP_SLVERR, 4'd4);

    // FIXED burst repeats the same word
    ar_send(32'h208, 8'd1, 3'd3, BURST_FIXED, 4'd4);
    exp_q.push_back(64'd2); exp_q.push_back(64'd2);
    r_get("fix", 2, 1'b0, RESP_OKAY, 4'd4);

    // 6: reset during beat 2 of a len7 read
    begin
      int n = 0;
      ar_send(32'h200, 8'd7, 3'd3, BURST_INCR, 4'd9);
      rready = 1;
      while (!rvalid && n < 20) begin tick(); n++; end
      check("t6_rvalid", 64'(rvalid), 64'd1);
      tick();
      tick();
      reset = 1;
      tick();
      rready = 0;
      check("t6_rst_rvalid", 64'(rvalid), 64'd0);
      check("t6_rst_arready", 64'(arready), 64'd1);
      check("t6_rst_rstate", 64'(r_state_dbg), 64'(R_IDLE));
      reset = 0;
      tick();
      ar_send(32'h200, 8'd0, 3'd3, BURST_INCR, 4'd4);
      exp_q.push_back(64'd1);
      r_get("t6", 1, 1'b0, RESP_OKAY, 4'd4);
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
